// File: rtl/mem_port_arbiter.sv
// Round-robin burst arbiter sharing one memory port between row loader (rd) and write-back (wr).
// Latency: grant one cycle after req is seen in IDLE; BURST_LEN beats, then one IDLE arbitration cycle.
// Backpressure: mem_ready low freezes address, direction and beat count; the non-granted requester sees stall.
module mem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int BURST_LEN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_stall,
    output logic              rd_beat,
    output logic              rd_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_stall,
    output logic              wr_beat,
    output logic              wr_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BURST_RD = 2'd1,
        BURST_WR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              last_wr_q, last_wr_d;
    logic              last_beat;
    logic              in_burst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            last_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            last_wr_q <= last_wr_d;
        end
    end

    assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));
    assign in_burst  = (state_q == BURST_RD) || (state_q == BURST_WR);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        last_wr_d = last_wr_q;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time gets the port.
                if (rd_req && (!wr_req || last_wr_q)) begin
                    state_d   = BURST_RD;
                    base_d    = rd_addr;
                    cnt_d     = '0;
                    last_wr_d = 1'b0;
                end else if (wr_req) begin
                    state_d   = BURST_WR;
                    base_d    = wr_addr;
                    cnt_d     = '0;
                    last_wr_d = 1'b1;
                end
            end
            BURST_RD, BURST_WR: begin
                if (mem_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_en   = in_burst;
    assign mem_we   = (state_q == BURST_WR);
    assign mem_addr = in_burst ? (base_q + ADDR_W'(cnt_q)) : '0;

    assign rd_beat  = (state_q == BURST_RD) && mem_ready;
    assign rd_done  = rd_beat && last_beat;
    assign wr_beat  = (state_q == BURST_WR) && mem_ready;
    assign wr_done  = wr_beat && last_beat;

    assign rd_stall = rd_req && (state_q != BURST_RD);
    assign wr_stall = wr_req && (state_q != BURST_WR);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the matrix unit's single-ported operand/result memory between the row loader and the result write-back path. It grants whole bursts on a round-robin basis and sequences BURST_LEN memory beats per grant. It drives the per-requester stall signals consumed upstream as mem_stall, so a requester that is not granted sees a stall. It sits between the iteration controller / output FIFO and the memory macro.

## Interface
- ADDR_W, 16, memory address width
- BURST_LEN, 2, beats per granted burst (≥1; normally set to M, one row)
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- rd_req  input  1  row-load burst request; held until rd_done
- rd_addr  input  ADDR_W  row-load base address; held until rd_done
- rd_stall  output  1  row-load requester blocked this cycle
- rd_beat  output  1  read beat accepted by memory this cycle
- rd_done  output  1  final read beat of burst accepted this cycle
- wr_req  input  1  write-back burst request; held until wr_done
- wr_addr  input  ADDR_W  write-back base address; held until wr_done
- wr_stall  output  1  write-back requester blocked this cycle
- wr_beat  output  1  write beat accepted by memory this cycle
- wr_done  output  1  final write beat of burst accepted this cycle
- mem_en  output  1  memory access valid
- mem_we  output  1  1 = write, 0 = read; valid with mem_en
- mem_addr  output  ADDR_W  memory address; valid with mem_en
- mem_ready  input  1  memory accepts the presented access this cycle

## Operation
- FSM states: IDLE, BURST_RD, BURST_WR. Reset → IDLE.
- IDLE: no mem access. At posedge, arbitration:
  - Only rd_req → BURST_RD. Only wr_req → BURST_WR. Neither → stay IDLE.
  - Both → grant the requester not granted last (last_grant register). Reset value of last_grant = WR, so the first tie goes to RD.
  - On grant: latch base address from the winner, clear beat counter, update last_grant.
- BURST_x:
  - mem_en=1, mem_addr = base + cnt (mod 2^ADDR_W, wraps silently), mem_we = 1 in BURST_WR, 0 in BURST_RD.
  - When mem_ready=1, x_beat=1 and cnt increments at the posedge.
  - When mem_ready=1 and cnt==BURST_LEN-1, x_done=1 and the FSM returns to IDLE at the posedge.
  - When mem_ready=0, hold all outputs and cnt unchanged.
- Stalls are combinational:
  - rd_stall = rd_req && state!=BURST_RD.
  - wr_stall = wr_req && state!=BURST_WR.
  - A requester with req=0 never sees a stall.
- Requester changes mid-burst:
  - Deasserting req mid-burst is ignored; the burst runs to completion.
  - Address changes mid-burst are ignored, because the base address is latched.
- beat/done outputs are combinational from state, cnt and mem_ready.
- Beat counter width is max(1,$clog2(BURST_LEN)).

## Timing
- Reset values:
  - state=IDLE, cnt=0, last_grant=WR, base=0.
  - mem_en=0, mem_we=0, mem_addr=0.
  - rd_beat=rd_done=wr_beat=wr_done=0.
  - rd_stall=rd_req, wr_stall=wr_req.
- Reset asserted mid-burst: the burst is abandoned immediately and asynchronously, with no done pulse. After release, arbitration resumes from IDLE.
- Grant latency: req high at posedge T in IDLE → first mem_en in cycle T+1.
- Burst of BURST_LEN beats with mem_ready held high occupies exactly BURST_LEN cycles. One IDLE arbitration cycle always separates consecutive bursts, so there are no back-to-back grants. Steady state is BURST_LEN+1 cycles per burst.
- Requesters update req on the posedge ending the x_done cycle. The value they drive is what arbitration sees in the following IDLE cycle.
- Both requesting continuously: grants strictly alternate RD, WR, RD, …
- BURST_LEN=1: each burst is one beat; done coincides with that beat.

## Test plan
- Reset: hold rst_n=0 with rd_req=wr_req=0 → mem_en=0, all beat/done=0, stalls=0. Assert rd_req during reset → rd_stall=1.
- Single read, BURST_LEN=2, rd_addr=0x0010, mem_ready=1:
  - mem_en one cycle after the req edge.
  - mem_addr 0x0010 then 0x0011, mem_we=0.
  - rd_beat on both beats, rd_done on the second beat.
  - Back to IDLE; rd_stall=1 only in the IDLE cycle.
- Contention: rd_req and wr_req raised together and held → bursts in order RD, WR, RD, WR, each separated by one IDLE cycle. During the write bursts rd_stall=1, and wr_stall=1 during the read bursts.
- Memory backpressure: wr burst with mem_ready low for 3 cycles on beat 0 → mem_addr and mem_we held stable, no wr_beat. The burst completes after mem_ready rises; total duration is 5 cycles.
- Address wrap: rd_addr=0xFFFF, BURST_LEN=2 → mem_addr 0xFFFF then 0x0000.
- Mid-burst disturbance:
  - Drop rd_req after the first beat → second beat still issued, rd_done still pulses.
  - Assert rst_n=0 mid-burst → mem_en falls immediately.
  - After release with rd_req=wr_req=1 → RD granted first.
